mem_load_align: RTL and testbench

- Load-return stage directly downstream of the store-mask/address stage. It sits between the synchronous memories (DMEM, BIOS, MMIO) and the writeback mux.
- Captures load control (funct3, byte offset, address region, rd) in the cycle the address is issued to memory.
- Selects the returning memory word by region, shifts by offset, then sign- or zero-extends.
- Registers the result for writeback.
- Preserves raw return data across pipeline stalls, because BRAM outputs are not stable while the pipe is stalled.

---
 rtl/mem_load_align_if.sv | 37 +++
 rtl/mem_load_align.sv | 74 +++++++
 tb/tb_mem_load_align.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_load_align_if.sv
// mem_load_align_if: bus between the load issue/return side and the load-align stage.
// Signals:
//   stall, flush, ld_valid_in, instr, addr_in         - issue-side control and address
//   dmem_dout, bios_dout, mmio_dout                   - memory read data, one cycle after address
//   ld_valid_out, ld_rd_out, ld_data_out              - registered writeback result
//   ld_misalign_out                                   - only with LOAD_MISALIGN_CHECK_EN
// Modports: master drives the pipe/memory side, slave is the align stage.
interface mem_load_align_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             flush;
  logic             ld_valid_in;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] addr_in;
  logic [WIDTH-1:0] dmem_dout;
  logic [WIDTH-1:0] bios_dout;
  logic [WIDTH-1:0] mmio_dout;
  logic             ld_valid_out;
  logic [4:0]       ld_rd_out;
  logic [WIDTH-1:0] ld_data_out;
`ifdef LOAD_MISALIGN_CHECK_EN
  logic             ld_misalign_out;
`endif
  modport master (
    output stall, flush, ld_valid_in, instr, addr_in, dmem_dout, bios_dout, mmio_dout,
`ifdef LOAD_MISALIGN_CHECK_EN
    input  ld_misalign_out,
`endif
    input  ld_valid_out, ld_rd_out, ld_data_out
  );
  modport slave (
    input  stall, flush, ld_valid_in, instr, addr_in, dmem_dout, bios_dout, mmio_dout,
`ifdef LOAD_MISALIGN_CHECK_EN
    output ld_misalign_out,
`endif
    output ld_valid_out, ld_rd_out, ld_data_out
  );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: load-return stage; selects memory word by region, aligns, extends, registers.
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_load_align_if.slave (stall/flush, issue fields, memory data, writeback outputs)
// Optional feature macro: LOAD_MISALIGN_CHECK_EN adds bus.ld_misalign_out.
module mem_load_align #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  mem_load_align_if.slave bus
);
  logic             a_valid;
  logic [2:0]       a_funct3;
  logic [1:0]       a_offset;
  logic [3:0]       a_region;
  logic [4:0]       a_rd;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] ext;
  logic             unused_bits;
  assign unused_bits = ^{bus.instr[WIDTH-1:15], bus.instr[6:0], bus.addr_in[WIDTH-5:2]};
  assign src = (a_region == 4'b0001 || a_region == 4'b0011) ? bus.dmem_dout :
               (a_region == 4'b0100) ? bus.bios_dout :
               (a_region == 4'b1000) ? bus.mmio_dout : '0;
  // BRAM output drifts during a stall, so the first stalled word is frozen in hold_reg
  assign raw = hold_valid ? hold_reg : src;
  assign shifted = raw >> {a_offset, 3'b000};
  assign ext = (a_funct3 == 3'b000) ? {{(WIDTH-8){shifted[7]}}, shifted[7:0]} :
               (a_funct3 == 3'b001) ? {{(WIDTH-16){shifted[15]}}, shifted[15:0]} :
               (a_funct3 == 3'b010) ? raw :
               (a_funct3 == 3'b100) ? {{(WIDTH-8){1'b0}}, shifted[7:0]} :
               (a_funct3 == 3'b101) ? {{(WIDTH-16){1'b0}}, shifted[15:0]} : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_valid          <= 1'b0;
      a_funct3         <= '0;
      a_offset         <= '0;
      a_region         <= '0;
      a_rd             <= '0;
      hold_valid       <= 1'b0;
      hold_reg         <= '0;
      bus.ld_valid_out <= 1'b0;
      bus.ld_rd_out    <= '0;
      bus.ld_data_out  <= '0;
    end else begin
      // flush wins over stall; other stage-A fields only move when not stalled
      a_valid <= ~bus.flush & (bus.stall ? a_valid : bus.ld_valid_in);
      if (!bus.stall) begin
        a_funct3         <= bus.instr[14:12];
        a_offset         <= bus.addr_in[1:0];
        a_region         <= bus.addr_in[WIDTH-1:WIDTH-4];
        a_rd             <= bus.instr[11:7];
        hold_valid       <= 1'b0;
        bus.ld_valid_out <= a_valid;
        bus.ld_rd_out    <= a_rd;
        bus.ld_data_out  <= ext;
      end else if (a_valid && !hold_valid) begin
        hold_reg   <= src;
        hold_valid <= 1'b1;
      end
    end
`ifdef LOAD_MISALIGN_CHECK_EN
  logic misalign;
  assign misalign = a_valid &
                    ((((a_funct3 == 3'b001) || (a_funct3 == 3'b101)) && a_offset[0]) ||
                     ((a_funct3 == 3'b010) && (a_offset != 2'b00)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.ld_misalign_out <= 1'b0;
    else if (!bus.stall) bus.ld_misalign_out <= misalign;
`endif
endmodule

// File: tb/tb_mem_load_align.sv
// tb_mem_load_align: directed vectors, corner sequences and random traffic against a reference model.
module tb_mem_load_align;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mem_load_align_if #(.WIDTH(32)) bus();
  mem_load_align #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] dmem;
    logic [31:0] bios;
    logic [31:0] mmio;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[12];
  // reference model: a load's word is whatever its region returns on the first edge after issue
  logic        m_v, m_fresh, e_v, e_mis;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [3:0]  m_rgn;
  logic [4:0]  m_rd, e_rd;
  logic [31:0] m_word, e_d;
  function automatic logic [31:0] word_for(input logic [3:0] r);
    if (r == 4'h1 || r == 4'h3) return bus.dmem_dout;
    if (r == 4'h4) return bus.bios_dout;
    if (r == 4'h8) return bus.mmio_dout;
    return 32'd0;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    longint unsigned s = longint'(w) / (64'd1 << (8 * off));
    longint unsigned b = s % 256;
    longint unsigned h = s % 65536;
    case (f3)
      3'd0: return 32'(b < 128 ? b : b + 64'hFFFF_FF00);
      3'd1: return 32'(h < 32768 ? h : h + 64'hFFFF_0000);
      3'd2: return w;
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return 32'd0;
    endcase
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_v <= 0; m_fresh <= 0; m_f3 <= 0; m_off <= 0; m_rgn <= 0; m_rd <= 0; m_word <= 0;
      e_v <= 0; e_rd <= 0; e_d <= 0; e_mis <= 0;
    end else if (!bus.stall) begin
      e_v     <= m_v;
      e_rd    <= m_rd;
      e_d     <= ref_load(m_f3, m_off, m_fresh ? word_for(m_rgn) : m_word);
      e_mis   <= m_v && (((m_f3 == 3'd1 || m_f3 == 3'd5) && m_off % 2 == 1) || (m_f3 == 3'd2 && m_off != 0));
      m_v     <= bus.ld_valid_in && !bus.flush;
      m_f3    <= bus.instr[14:12];
      m_rd    <= bus.instr[11:7];
      m_off   <= bus.addr_in[1:0];
      m_rgn   <= bus.addr_in[31:28];
      m_fresh <= 1;
    end else begin
      if (bus.flush) m_v <= 0;
      if (m_fresh) begin
        m_word  <= word_for(m_rgn);
        m_fresh <= 0;
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr);
    bus.ld_valid_in = 1'b1;
    bus.instr = {17'd0, f3, rd, 7'b0000011};
    bus.addr_in = addr;
    tick();
    bus.ld_valid_in = 1'b0;
  endtask
  task automatic chk_out(input string nm, input logic v, input logic [4:0] rd, input logic [31:0] d);
    chk({nm, " valid"}, 32'(bus.ld_valid_out), 32'(v));
    chk({nm, " rd"}, 32'(bus.ld_rd_out), 32'(rd));
    chk({nm, " data"}, bus.ld_data_out, d);
  endtask
  initial begin
    logic [31:0] a;
    bus.stall = 0; bus.flush = 0; bus.ld_valid_in = 0; bus.instr = 0; bus.addr_in = 0;
    bus.dmem_dout = 0; bus.bios_dout = 0; bus.mmio_dout = 0;
    vt[0]  = '{3'd2, 5'd5,  32'h1000_0000, 32'hDEADBEEF, 32'h1111_1111, 32'h2222_2222, 32'hDEADBEEF};
    vt[1]  = '{3'd0, 5'd6,  32'h4000_0002, 32'hAAAA_AAAA, 32'h12F4_5678, 32'h5555_5555, 32'hFFFF_FFF4};
    vt[2]  = '{3'd4, 5'd7,  32'h4000_0002, 32'hAAAA_AAAA, 32'h12F4_5678, 32'h5555_5555, 32'h0000_00F4};
    vt[3]  = '{3'd5, 5'd8,  32'h4000_0002, 32'hAAAA_AAAA, 32'h12F4_5678, 32'h5555_5555, 32'h0000_12F4};
    vt[4]  = '{3'd2, 5'd9,  32'h7000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h0000_0000};
    vt[5]  = '{3'd1, 5'd10, 32'h1000_0003, 32'h80FF_FFFF, 32'h0, 32'h0, 32'h0000_0080};
    vt[6]  = '{3'd2, 5'd11, 32'h8000_0000, 32'h1111_1111, 32'h2222_2222, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vt[7]  = '{3'd0, 5'd12, 32'h3000_0001, 32'h0000_8000, 32'h0, 32'h0, 32'hFFFF_FF80};
    vt[8]  = '{3'd3, 5'd13, 32'h1000_0000, 32'h1234_5678, 32'h0, 32'h0, 32'h0000_0000};
    vt[9]  = '{3'd1, 5'd14, 32'h1000_0000, 32'h1234_7FFF, 32'h0, 32'h0, 32'h0000_7FFF};
    vt[10] = '{3'd5, 5'd15, 32'h3000_0002, 32'h8001_0000, 32'h0, 32'h0, 32'h0000_8001};
    vt[11] = '{3'd1, 5'd31, 32'h4000_0002, 32'h0, 32'h8001_0000, 32'h0, 32'hFFFF_8001};
    #12;
    chk_out("reset", 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    foreach (vt[i]) begin
      issue(vt[i].f3, vt[i].rd, vt[i].addr);
      bus.dmem_dout = vt[i].dmem; bus.bios_dout = vt[i].bios; bus.mmio_dout = vt[i].mmio;
      tick();
      chk_out($sformatf("vec%0d", i), 1'b1, vt[i].rd, vt[i].exp);
    end
    // stall hold: LH of 0x8001 survives three stall cycles while DMEM goes to zero
    bus.instr = 0; bus.addr_in = 0;
    tick(); tick();
    issue(3'd1, 5'd20, 32'h1000_0000);
    bus.dmem_dout = 32'h0000_8001; bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.dmem_dout = 0;
      chk_out($sformatf("stall%0d", k), 1'b0, 5'd0, 32'd0);
    end
    bus.stall = 0;
    tick();
    chk_out("stall_release", 1'b1, 5'd20, 32'hFFFF_8001);
    // flush + back-to-back: A, B(flushed on capture), C
    bus.ld_valid_in = 1; bus.instr = {17'd0, 3'd2, 5'd1, 7'b0000011}; bus.addr_in = 32'h1000_0000;
    tick();
    bus.instr = {17'd0, 3'd2, 5'd2, 7'b0000011}; bus.flush = 1; bus.dmem_dout = 32'hAAAA_0001;
    tick();
    chk_out("flush_A", 1'b1, 5'd1, 32'hAAAA_0001);
    bus.instr = {17'd0, 3'd2, 5'd3, 7'b0000011}; bus.flush = 0; bus.dmem_dout = 32'hBBBB_0002;
    tick();
    chk("flush_B valid", 32'(bus.ld_valid_out), 32'd0);
    bus.ld_valid_in = 0; bus.dmem_dout = 32'hCCCC_0003;
    tick();
    chk_out("flush_C", 1'b1, 5'd3, 32'hCCCC_0003);
    // asynchronous reset mid-load, then a normal load
    issue(3'd2, 5'd9, 32'h1000_0000);
    bus.dmem_dout = 32'hDEAD_BEEF;
    issue(3'd2, 5'd9, 32'h1000_0000);
    chk_out("pre_reset", 1'b1, 5'd9, 32'hDEAD_BEEF);
    #3 rst_n = 1'b0;
    #1 chk_out("async_reset", 1'b0, 5'd0, 32'd0);
    #3 rst_n = 1'b1;
    issue(3'd4, 5'd17, 32'h4000_0001);
    bus.bios_dout = 32'h12F4_5678;
    tick();
    chk_out("post_reset", 1'b1, 5'd17, 32'h0000_0056);
`ifdef LOAD_MISALIGN_CHECK_EN
    issue(3'd2, 5'd4, 32'h1000_0001);
    tick();
    chk("misalign_lw1", 32'(bus.ld_misalign_out), 32'd1);
`endif
    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 6) == 0);
      bus.ld_valid_in = ($urandom_range(0, 9) < 7);
      bus.instr = $urandom;
      a = $urandom;
      case ($urandom_range(0, 5))
        0: a[31:28] = 4'h1;
        1: a[31:28] = 4'h3;
        2: a[31:28] = 4'h4;
        3: a[31:28] = 4'h8;
        default: ;
      endcase
      bus.addr_in = a;
      bus.dmem_dout = $urandom; bus.bios_dout = $urandom; bus.mmio_dout = $urandom;
      tick();
      chk($sformatf("rnd%0d valid", c), 32'(bus.ld_valid_out), 32'(e_v));
      chk($sformatf("rnd%0d rd", c), 32'(bus.ld_rd_out), 32'(e_rd));
      if (e_v) chk($sformatf("rnd%0d data", c), bus.ld_data_out, e_d);
`ifdef LOAD_MISALIGN_CHECK_EN
      chk($sformatf("rnd%0d misalign", c), 32'(bus.ld_misalign_out), 32'(e_mis));
`endif
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
